// File: rtl/data_ram.sv
// Single-port data memory for the rv32i load/store path: byte/half/word accesses,
// byte-lane stores, sign/zero-extended loads, one registered response per request.
module data_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_fault
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW+1:0] rel_addr;
    logic [AW-1:0] word_idx;
    logic [1:0]    offset;
    logic          illegal;
    logic          is_half;
    logic          is_word;
    logic          misaligned;
    logic          out_of_range;
    logic          any_err;
    logic [3:0]    byte_en;
    logic [31:0]   lane_data;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic          do_write;

    logic          valid_q;
    logic [31:0]   rdata_q;
    logic          misaligned_q;
    logic          fault_q;

    // Only the low bits matter: BASE_ADDR is aligned to the memory size.
    assign rel_addr = req_addr[AW+1:0] - BASE_ADDR[AW+1:0];
    assign word_idx = rel_addr[AW+1:2];
    assign offset   = rel_addr[1:0];

    // NOTE: every signal assigned in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        illegal   = 1'b1;
        is_half   = 1'b0;
        is_word   = 1'b0;
        case (funct3_e'(req_funct3))
            F3_B:    illegal = 1'b0;
            F3_H:    begin illegal = 1'b0;   is_half = 1'b1; end
            F3_W:    begin illegal = 1'b0;   is_word = 1'b1; end
            F3_BU:   illegal = req_we;
            F3_HU:   begin illegal = req_we; is_half = 1'b1; end
            default: illegal = 1'b1;
        endcase

        misaligned   = !illegal && ((is_half && offset[0]) || (is_word && offset != 2'b00));
        out_of_range = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) || ({1'b0, req_addr} >= END_ADDR);
        any_err      = illegal || misaligned || out_of_range;

        if (is_word) begin
            byte_en   = 4'b1111;
            lane_data = req_wdata;
        end else if (is_half) begin
            byte_en   = 4'b0011 << offset;
            lane_data = {2{req_wdata[15:0]}};
        end else begin
            byte_en   = 4'b0001 << offset;
            lane_data = {4{req_wdata[7:0]}};
        end

        shifted = mem[word_idx] >> {offset, 3'b000};
        case (funct3_e'(req_funct3))
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign do_write = req_valid && req_we && !any_err && !reset;

    // NOTE: the memory array has no reset branch; contents survive reset and start undefined.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rdata_q      <= 32'h0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            valid_q      <= req_valid;
            rdata_q      <= (req_valid && !req_we && !any_err) ? load_data : 32'h0;
            misaligned_q <= req_valid && misaligned;
            fault_q      <= req_valid && (illegal || out_of_range);
        end
    end

    // A reset landing while a response is on the outputs kills it immediately.
    assign rsp_valid      = valid_q && !reset;
    assign rsp_rdata      = reset ? 32'h0 : rdata_q;
    assign rsp_misaligned = misaligned_q && !reset;
    assign rsp_fault      = fault_q && !reset;

endmodule

// File: tb/tb_data_ram.sv
// Directed and model-checked bench for data_ram (DEPTH_WORDS=1024, BASE_ADDR=0).
module tb_data_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [64];

    data_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .rsp_fault      (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [31:0] rd,
                             input logic mis, input logic flt);
        check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        check({tag, ".rdata"}, rsp_rdata, rd);
        check({tag, ".misaligned"}, 32'(rsp_misaligned), 32'(mis));
        check({tag, ".fault"}, 32'(rsp_fault), 32'(flt));
    endtask

    // Presents one request for one cycle; on return the response is on the outputs.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic model_store(input logic [2:0] f3, input int addr, input logic [31:0] wd);
        int n;
        n = (f3 == 3'b010) ? 4 : (f3 == 3'b001) ? 2 : 1;
        for (int i = 0; i < n; i++) model_mem[addr + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int addr);
        logic [31:0] v;
        case (f3)
            3'b000:  v = {{24{model_mem[addr][7]}}, model_mem[addr]};
            3'b100:  v = {24'h0, model_mem[addr]};
            3'b001:  v = {{16{model_mem[addr+1][7]}}, model_mem[addr+1], model_mem[addr]};
            3'b101:  v = {16'h0, model_mem[addr+1], model_mem[addr]};
            default: v = {model_mem[addr+3], model_mem[addr+2], model_mem[addr+1], model_mem[addr]};
        endcase
        return v;
    endfunction

    initial begin
        logic [2:0]  ld_f3 [5];
        logic [2:0]  f3;
        int          addr;
        logic [31:0] wd;

        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_rsp("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        // Word store then load, then byte lanes and extension.
        send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);  check_rsp("sw_0x10", 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b0, 3'b010, 32'h10, 32'h0);         check_rsp("lw_0x10", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        send(1'b1, 3'b000, 32'h12, 32'h80);        check_rsp("sb_0x12", 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b0, 3'b010, 32'h10, 32'h0);         check_rsp("lw_after_sb", 1'b1, 32'hDE80BEEF, 1'b0, 1'b0);
        send(1'b0, 3'b000, 32'h12, 32'h0);         check_rsp("lb_0x12", 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
        send(1'b0, 3'b100, 32'h12, 32'h0);         check_rsp("lbu_0x12", 1'b1, 32'h00000080, 1'b0, 1'b0);
        send(1'b0, 3'b001, 32'h10, 32'h0);         check_rsp("lh_0x10", 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0);
        send(1'b0, 3'b101, 32'h12, 32'h0);         check_rsp("lhu_0x12", 1'b1, 32'h0000DE80, 1'b0, 1'b0);

        // Misaligned accesses have no side effects.
        send(1'b1, 3'b010, 32'h11, 32'h12345678);  check_rsp("sw_mis", 1'b1, 32'h0, 1'b1, 1'b0);
        send(1'b0, 3'b010, 32'h10, 32'h0);         check_rsp("lw_after_mis", 1'b1, 32'hDE80BEEF, 1'b0, 1'b0);
        send(1'b0, 3'b001, 32'h13, 32'h0);         check_rsp("lh_mis", 1'b1, 32'h0, 1'b1, 1'b0);

        // Range boundary and illegal funct3.
        send(1'b0, 3'b010, 32'h1000, 32'h0);       check_rsp("lw_oor", 1'b1, 32'h0, 1'b0, 1'b1);
        send(1'b0, 3'b010, 32'h1001, 32'h0);       check_rsp("lw_oor_mis", 1'b1, 32'h0, 1'b1, 1'b1);
        send(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0);  check_rsp("lw_top", 1'b1, 32'h0, 1'b0, 1'b1);
        send(1'b1, 3'b010, 32'h0FFC, 32'hCAFEF00D); check_rsp("sw_last", 1'b1, 32'h0, 1'b0, 1'b0);
        send(1'b0, 3'b010, 32'h0FFC, 32'h0);       check_rsp("lw_last", 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
        send(1'b1, 3'b100, 32'h10, 32'h55);        check_rsp("sb_f3_100", 1'b1, 32'h0, 1'b0, 1'b1);
        send(1'b0, 3'b011, 32'h11, 32'h0);         check_rsp("f3_011", 1'b1, 32'h0, 1'b0, 1'b1);
        send(1'b0, 3'b010, 32'h10, 32'h0);         check_rsp("lw_after_illegal", 1'b1, 32'hDE80BEEF, 1'b0, 1'b0);
        idle();                                    check_rsp("idle", 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset mid-stream.
        send(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5);  check_rsp("sw_0x20", 1'b1, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        send(1'b1, 3'b010, 32'h20, 32'h11111111);  check_rsp("sw_in_reset", 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        send(1'b0, 3'b010, 32'h20, 32'h0);
        reset = 1'b1;
        #1;                                        check_rsp("lw_killed", 1'b0, 32'h0, 1'b0, 1'b0);
        idle();                                    check_rsp("lw_killed_edge", 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        idle();                                    check_rsp("post_reset_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        send(1'b0, 3'b010, 32'h20, 32'h0);         check_rsp("store_dropped", 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        send(1'b1, 3'b010, 32'h24, 32'h77665544);
        reset = 1'b1;
        #1;                                        check_rsp("sw_killed", 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        reset = 1'b0;
        send(1'b0, 3'b010, 32'h24, 32'h0);         check_rsp("store_committed", 1'b1, 32'h77665544, 1'b0, 1'b0);

        // Model-checked back-to-back traffic over the first 64 bytes.
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            send(1'b1, 3'b010, 32'(w * 4), wd);
            model_store(3'b010, w * 4, wd);
            check("init.valid", 32'(rsp_valid), 32'h1);
        end
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = ld_f3[$urandom_range(0, 4)];
            end
            case (f3)
                3'b010:          addr = 4 * $urandom_range(0, 15);
                3'b001, 3'b101:  addr = 2 * $urandom_range(0, 31);
                default:         addr = $urandom_range(0, 63);
            endcase
            wd = $urandom;
            send(i % 2 == 0, f3, 32'(addr), wd);
            check($sformatf("rand%0d.valid", i), 32'(rsp_valid), 32'h1);
            if (i % 2 == 0) begin
                model_store(f3, addr, wd);
                check($sformatf("rand%0d.st_rdata", i), rsp_rdata, 32'h0);
            end else begin
                check($sformatf("rand%0d.ld_rdata", i), rsp_rdata, model_load(f3, addr));
            end
        end
        idle();                                    check_rsp("final_idle", 1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram.md
# data_ram

Parametrised single-port data memory for the rv32i core's load/store path. Each request is one access: byte, halfword or word. Stores use byte lanes; loads return zero- or sign-extended data. Misaligned, out-of-range and illegal-size requests are flagged and have no side effects. The block sits behind the memory stage and returns one registered response per request, exactly one cycle after the request.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, ≥ 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  a request is present this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size and sign, using RV32I funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (the byte or halfword sits in the low bits).
- rsp_valid  out  1  response for the previous cycle's request.
- rsp_rdata  out  32  load result, extended to 32 bits.
- rsp_misaligned  out  1  previous request was misaligned.
- rsp_fault  out  1  previous request was out of range or had an illegal funct3.

## Operation
- Word index = (req_addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. Byte offset = req_addr[1:0].
- Out of range: req_addr < BASE_ADDR or req_addr ≥ BASE_ADDR + DEPTH_WORDS*4. Compare in 33 bits so the upper bound cannot wrap.
- funct3 decode:
  - 000: LB/SB
  - 001: LH/SH
  - 010: LW/SW
  - 100: LBU (load only)
  - 101: LHU (load only)
  - Any other value is illegal. 100 and 101 are also illegal for stores.
- Misaligned: halfword access with offset[0]=1, or word access with offset≠0. Not evaluated for illegal funct3.
- Error priority: an illegal funct3 sets only rsp_fault. Otherwise misaligned and out-of-range are flagged independently; both flags can be 1 at once.
- Stores with no error write byte lanes only:
  - SB: lane = offset, data = wdata[7:0].
  - SH: lanes offset and offset+1, data = wdata[15:0].
  - SW: all four lanes.
  - Lanes not written keep their old value.
- Any error suppresses the write entirely.
- Loads read the addressed word. The word is shifted right by offset*8, then bits above the access size are sign-extended (LB/LH) or zero-filled (LBU/LHU/LW).
- Responses:
  - Every accepted request gives exactly one response.
  - A store response has rsp_rdata = 0.
  - A response with any error has rsp_rdata = 0.
- Memory contents are not cleared by reset and are undefined at power-up.
- There is no backpressure: a request is accepted every cycle that req_valid=1.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, rsp_fault=0.
- A request in the same cycle as reset=1 is dropped: no write takes place and no response follows.
- Reset arriving the cycle after a request kills that request's pending response (rsp_valid=0). A store from that request has already been committed.
- Latency is 1: a request at edge N gives its response outputs valid after edge N+1. Responses can be back-to-back every cycle.
- Read-after-write: a load at cycle N+1 to the word stored at cycle N returns the new data.
- One access per cycle. A store and a load never occur in the same cycle.
- With req_valid=0, next cycle's rsp_valid=0 and the other outputs are 0.

## Test plan
- Store then load, word: SW 0xDEADBEEF to 0x10, then LW 0x10 on the next cycle → rsp_rdata=0xDEADBEEF with no flags. The store's own response has rsp_rdata=0.
- Byte lanes and sign extension, using the word at 0x10 = 0xDEADBEEF:
  - SB 0x80 to 0x12 → the word becomes 0xDE80BEEF.
  - LB 0x12 → 0xFFFFFF80.
  - LBU 0x12 → 0x00000080.
  - LH 0x10 → 0xFFFFBEEF.
  - LHU 0x12 → 0x0000DE80.
- Misaligned: SW to 0x11 sets rsp_misaligned=1; a following LW 0x10 returns the word unchanged. LH at 0x13 sets rsp_misaligned=1 with rsp_rdata=0.
- Out of range and illegal size, with DEPTH_WORDS=1024 and BASE_ADDR=0:
  - LW 0x1000 → rsp_fault=1.
  - LW 0x0FFC → reads successfully.
  - SB with funct3=100 → rsp_fault=1, no write.
  - funct3=011 → rsp_fault=1.
- Reset mid-stream: a store is issued while reset=1, and reset also asserts the cycle after a load request. Required: both responses are suppressed (rsp_valid=0), the store does not land, and all outputs are 0.
- Back-to-back: 64 alternating random stores and loads with a reference model. Check rsp_valid on every cycle and that every load matches the model.
